// File: rtl/stack_sequencer.sv
// Stack pointer owner and multi-word PUSH/POP/CALL/RET/INT/RETI sequencer for the decode-stage controller.
// Define STACK_BOUNDS_CHECK_EN to suppress out-of-range stack accesses and raise the sticky stack_err.
module stack_sequencer #(
    parameter int unsigned       ADDR_W      = 12,
    parameter logic [ADDR_W-1:0] SP_RESET    = 12'hFFF,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = 12'hF00,
    parameter logic [31:0]       INT_VECTOR  = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [15:0]       req_data,
    input  logic [31:0]       req_pc,
    input  logic [31:0]       req_target,
    input  logic [3:0]        req_flags,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pc_load,
    output logic [31:0]       pc_value,
    output logic              flags_load,
    output logic [3:0]        flags_value,
    output logic              pop_valid,
    output logic [15:0]       pop_data,
    output logic [ADDR_W-1:0] sp,
    output logic              stack_err
);

    typedef enum logic [2:0] {
        OP_PUSH = 3'd0,
        OP_POP  = 3'd1,
        OP_CALL = 3'd2,
        OP_RET  = 3'd3,
        OP_INT  = 3'd4,
        OP_RETI = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSHING,
        S_POPPING,
        S_DRAIN,
        S_DONE
    } state_e;

    function automatic logic [1:0] last_idx(input logic [2:0] op);
        case (op)
            OP_CALL, OP_RET:  return 2'd1;
            OP_INT,  OP_RETI: return 2'd2;
            default:          return 2'd0;
        endcase
    endfunction

    state_e            r_state;
    state_e            w_next;
    op_e               r_op;
    logic [15:0]       r_data;
    logic [31:0]       r_pc;
    logic [31:0]       r_target;
    logic [3:0]        r_flags;
    logic [1:0]        r_cnt;
    logic [1:0]        r_last;
    logic [ADDR_W-1:0] r_sp;
    logic              r_rd_pend;
    logic              r_rd_sup;
    logic [1:0]        r_rd_idx;
    logic [15:0]       r_word [3];

    logic              r_done;
    logic              r_pc_load;
    logic [31:0]       r_pc_value;
    logic              r_flags_load;
    logic [3:0]        r_flags_value;
    logic              r_pop_valid;
    logic [15:0]       r_pop_data;

    logic              w_legal;
    logic              w_is_push_op;
    logic              w_accept;
    logic              w_push_ok;
    logic              w_pop_ok;
    logic              w_push_act;
    logic              w_pop_act;
    logic [15:0]       w_push_word;
    logic [15:0]       w_cap;
    logic [15:0]       w_word [3];

    assign w_legal      = (req_op <= OP_RETI);
    assign w_is_push_op = (req_op == OP_PUSH) || (req_op == OP_CALL) || (req_op == OP_INT);
    assign w_accept     = (r_state == S_IDLE) && req_valid && w_legal;

`ifdef STACK_BOUNDS_CHECK_EN
    logic r_err;

    assign w_push_ok = (r_sp >= STACK_LIMIT);
    assign w_pop_ok  = (r_sp != SP_RESET);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (((r_state == S_PUSHING) && !w_push_ok) ||
                     ((r_state == S_POPPING) && !w_pop_ok)) begin
            r_err <= 1'b1;
        end
    end

    assign stack_err = r_err;
`else
    assign w_push_ok = 1'b1;
    assign w_pop_ok  = 1'b1;
    assign stack_err = 1'b0;
`endif

    assign w_push_act = (r_state == S_PUSHING) && w_push_ok;
    assign w_pop_act  = (r_state == S_POPPING) && w_pop_ok;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = w_is_push_op ? S_PUSHING : S_POPPING;
            S_PUSHING: if (r_cnt == r_last) w_next = S_DONE;
            S_POPPING: if (r_cnt == r_last) w_next = S_DRAIN;
            S_DRAIN:   w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Return-address words go high half first so RET/RETI pop the low half first.
    always_comb begin
        w_push_word = r_data;
        case (r_op)
            OP_CALL: w_push_word = (r_cnt == 2'd0) ? r_pc[31:16] : r_pc[15:0];
            OP_INT: begin
                case (r_cnt)
                    2'd0:    w_push_word = r_pc[31:16];
                    2'd1:    w_push_word = r_pc[15:0];
                    default: w_push_word = {12'b0, r_flags};
                endcase
            end
            default: w_push_word = r_data;
        endcase
    end

    // A suppressed read returns zero; the freshest word bypasses into the DONE result.
    assign w_cap = r_rd_sup ? 16'h0000 : mem_rdata;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_word[i] = (r_rd_pend && (r_rd_idx == 2'(i))) ? w_cap : r_word[i];
        end
    end

    assign mem_we    = w_push_act;
    assign mem_re    = w_pop_act;
    assign mem_wdata = w_push_act ? w_push_word : 16'h0000;
    assign mem_addr  = w_push_act ? r_sp : (w_pop_act ? r_sp + ADDR_W'(1) : '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_op          <= OP_PUSH;
            r_data        <= '0;
            r_pc          <= '0;
            r_target      <= '0;
            r_flags       <= '0;
            r_cnt         <= '0;
            r_last        <= '0;
            r_sp          <= SP_RESET;
            r_rd_pend     <= 1'b0;
            r_rd_sup      <= 1'b0;
            r_rd_idx      <= '0;
            // NOTE: the capture words are plain flops, not RAM, so they reset like everything else.
            for (int i = 0; i < 3; i++) r_word[i] <= '0;
            r_done        <= 1'b0;
            r_pc_load     <= 1'b0;
            r_pc_value    <= '0;
            r_flags_load  <= 1'b0;
            r_flags_value <= '0;
            r_pop_valid   <= 1'b0;
            r_pop_data    <= '0;
        end else begin
            r_state <= w_next;

            if (w_accept) begin
                r_op     <= op_e'(req_op);
                r_data   <= req_data;
                r_pc     <= req_pc;
                r_target <= req_target;
                r_flags  <= req_flags;
                r_cnt    <= '0;
                r_last   <= last_idx(req_op);
            end else if ((r_state == S_PUSHING) || (r_state == S_POPPING)) begin
                r_cnt <= r_cnt + 2'd1;
            end

            if (w_push_act)     r_sp <= r_sp - ADDR_W'(1);
            else if (w_pop_act) r_sp <= r_sp + ADDR_W'(1);

            r_rd_pend <= (r_state == S_POPPING);
            r_rd_sup  <= !w_pop_ok;
            r_rd_idx  <= r_cnt;
            for (int i = 0; i < 3; i++) begin
                if (r_rd_pend && (r_rd_idx == 2'(i))) r_word[i] <= w_cap;
            end

            r_done        <= 1'b0;
            r_pc_load     <= 1'b0;
            r_pc_value    <= '0;
            r_flags_load  <= 1'b0;
            r_flags_value <= '0;
            r_pop_valid   <= 1'b0;
            r_pop_data    <= '0;
            if (w_next == S_DONE) begin
                r_done <= 1'b1;
                case (r_op)
                    OP_POP: begin
                        r_pop_valid <= 1'b1;
                        r_pop_data  <= w_word[0];
                    end
                    OP_CALL: begin
                        r_pc_load  <= 1'b1;
                        r_pc_value <= r_target;
                    end
                    OP_INT: begin
                        r_pc_load  <= 1'b1;
                        r_pc_value <= INT_VECTOR;
                    end
                    OP_RET: begin
                        r_pc_load  <= 1'b1;
                        r_pc_value <= {w_word[1], w_word[0]};
                    end
                    OP_RETI: begin
                        r_pc_load     <= 1'b1;
                        r_pc_value    <= {w_word[2], w_word[1]};
                        r_flags_load  <= 1'b1;
                        r_flags_value <= w_word[0][3:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign busy        = !req_ready;
    assign done        = r_done;
    assign pc_load     = r_pc_load;
    assign pc_value    = r_pc_value;
    assign flags_load  = r_flags_load;
    assign flags_value = r_flags_value;
    assign pop_valid   = r_pop_valid;
    assign pop_data    = r_pop_data;
    assign sp          = r_sp;

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer: a behavioural stack model predicts memory traffic and
// completion results; a negedge monitor compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_stack_sequencer;

    localparam logic [11:0] SP_RST = 12'hFFF;
    localparam logic [11:0] LIMIT  = 12'hF00;
    localparam logic [31:0] VEC    = 32'h0000_0000;
`ifdef STACK_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_data;
    logic [31:0] req_pc;
    logic [31:0] req_target;
    logic [3:0]  req_flags;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        pc_load;
    logic [31:0] pc_value;
    logic        flags_load;
    logic [3:0]  flags_value;
    logic        pop_valid;
    logic [15:0] pop_data;
    logic [11:0] sp;
    logic        stack_err;

    stack_sequencer dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data), .req_pc(req_pc), .req_target(req_target),
        .req_flags(req_flags), .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .done(done),
        .pc_load(pc_load), .pc_value(pc_value), .flags_load(flags_load),
        .flags_value(flags_value), .pop_valid(pop_valid), .pop_data(pop_data),
        .sp(sp), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory behind the DUT: one-cycle read latency.
    logic [15:0] tb_mem [4096];
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= tb_mem[mem_addr];
    end

    typedef struct {
        bit          we;
        logic [11:0] addr;
        logic [15:0] data;
        int          cyc;
    } mem_exp_t;

    typedef struct {
        bit          pc_load;
        logic [31:0] pc;
        bit          flags_load;
        logic [3:0]  flags;
        bit          pop_valid;
        logic [15:0] pop;
        logic [11:0] sp;
        bit          err;
        int          cyc;
    } done_exp_t;

    mem_exp_t  mem_q [$];
    done_exp_t done_q [$];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: a word-addressed stack growing downward from SP_RST.
    logic [15:0] model_mem [4096];
    logic [11:0] m_sp;
    bit          m_err;

    task automatic model_req(input logic [2:0] op, input logic [15:0] d, input logic [31:0] pc,
                             input logic [31:0] tgt, input logic [3:0] fl, input int c0);
        logic [15:0] w [3];
        int n;
        mem_exp_t  me;
        done_exp_t de;
        de = '{default: 0};
        w[0] = '0; w[1] = '0; w[2] = '0;
        if (op == 3'd0 || op == 3'd2 || op == 3'd4) begin
            case (op)
                3'd0:    begin w[0] = d; n = 1; end
                3'd2:    begin w[0] = pc[31:16]; w[1] = pc[15:0]; n = 2; end
                default: begin w[0] = pc[31:16]; w[1] = pc[15:0]; w[2] = {12'b0, fl}; n = 3; end
            endcase
            for (int k = 0; k < n; k++) begin
                if (BOUNDS && m_sp < LIMIT) begin
                    m_err = 1'b1;
                end else begin
                    me.we = 1'b1; me.addr = m_sp; me.data = w[k]; me.cyc = c0 + k + 1;
                    mem_q.push_back(me);
                    model_mem[m_sp] = w[k];
                    m_sp = m_sp - 12'd1;
                end
            end
            de.cyc = c0 + n + 1;
            if (op == 3'd2) begin de.pc_load = 1'b1; de.pc = tgt; end
            if (op == 3'd4) begin de.pc_load = 1'b1; de.pc = VEC; end
        end else begin
            n = (op == 3'd1) ? 1 : (op == 3'd3) ? 2 : 3;
            for (int k = 0; k < n; k++) begin
                if (BOUNDS && m_sp == SP_RST) begin
                    w[k] = '0;
                    m_err = 1'b1;
                end else begin
                    m_sp = m_sp + 12'd1;
                    me.we = 1'b0; me.addr = m_sp; me.data = '0; me.cyc = c0 + k + 1;
                    mem_q.push_back(me);
                    w[k] = model_mem[m_sp];
                end
            end
            de.cyc = c0 + n + 2;
            case (op)
                3'd1:    begin de.pop_valid = 1'b1; de.pop = w[0]; end
                3'd3:    begin de.pc_load = 1'b1; de.pc = {w[1], w[0]}; end
                default: begin
                    de.pc_load = 1'b1; de.pc = {w[2], w[1]};
                    de.flags_load = 1'b1; de.flags = w[0][3:0];
                end
            endcase
        end
        de.sp  = m_sp;
        de.err = m_err;
        done_q.push_back(de);
    endtask

    // Monitor: compares every memory strobe and every completion against the scoreboard.
    mem_exp_t  mon_me;
    done_exp_t mon_de;
    always @(negedge clk) begin
        if (reset) begin
            if (mem_we || mem_re) begin
                if (mem_q.size() == 0) begin
                    check("mem_unexpected", {mem_we, mem_re}, 2'b00);
                end else begin
                    mon_me = mem_q.pop_front();
                    check("mem_we", mem_we, mon_me.we);
                    check("mem_re", mem_re, !mon_me.we);
                    check("mem_addr", mem_addr, mon_me.addr);
                    if (mon_me.we) check("mem_wdata", mem_wdata, mon_me.data);
                    check("mem_cycle", cyc, mon_me.cyc);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", done, 1'b0);
                end else begin
                    mon_de = done_q.pop_front();
                    check("done_cycle", cyc, mon_de.cyc);
                    check("pc_load", pc_load, mon_de.pc_load);
                    check("pc_value", pc_value, mon_de.pc);
                    check("flags_load", flags_load, mon_de.flags_load);
                    check("flags_value", flags_value, mon_de.flags);
                    check("pop_valid", pop_valid, mon_de.pop_valid);
                    check("pop_data", pop_data, mon_de.pop);
                    check("done_sp", sp, mon_de.sp);
                    check("stack_err", stack_err, mon_de.err);
                    check("done_ready", req_ready, 1'b0);
                end
            end else if (pc_load || flags_load || pop_valid) begin
                check("stray_result", {pc_load, flags_load, pop_valid}, 3'b000);
            end
        end
    end

    task automatic reset_checks();
        check("rst_sp", sp, SP_RST);
        check("rst_ready", req_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_strobes", {mem_we, mem_re, done, pc_load, flags_load, pop_valid}, 6'b0);
        check("rst_addr", mem_addr, 12'h000);
        check("rst_wdata", mem_wdata, 16'h0000);
        check("rst_pc_value", pc_value, 32'h0);
        check("rst_flags_value", flags_value, 4'h0);
        check("rst_pop_data", pop_data, 16'h0000);
        check("rst_err", stack_err, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        mem_q.delete();
        done_q.delete();
        m_sp  = SP_RST;
        m_err = 1'b0;
        @(negedge clk);
        reset_checks();
        reset = 1'b1;
    endtask

    task automatic wait_idle();
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!req_ready && g < 40);
        if (!req_ready) check("idle_timeout", req_ready, 1'b1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] d, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic [3:0] fl);
        @(negedge clk);
        req_op = op; req_data = d; req_pc = pc; req_target = tgt; req_flags = fl;
        req_valid = 1'b1;
        if (!req_ready) check("accept_ready", req_ready, 1'b1);
        model_req(op, d, pc, tgt, fl, cyc);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_idle();
    endtask

    task automatic issue_illegal(input logic [2:0] op);
        @(negedge clk);
        req_op = op;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("illegal_idle", req_ready, 1'b1);
        check("illegal_sp", sp, m_sp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        logic [11:0] a3;
        logic [15:0] saved;
        logic [2:0]  op;

        for (int i = 0; i < 4096; i++) begin
            tb_mem[i]    = '0;
            model_mem[i] = '0;
        end
        mem_rdata = '0;
        reset = 1'b0;
        req_valid = 1'b0; req_op = '0; req_data = '0; req_pc = '0; req_target = '0; req_flags = '0;
        m_sp = SP_RST; m_err = 1'b0;
        repeat (3) @(negedge clk);
        reset_checks();
        reset = 1'b1;

        // CALL then RET round trip.
        issue(3'd2, 16'h0, 32'h0001_2345, 32'h0000_0100, 4'h0);
        check("call_sp", sp, 12'hFFD);
        issue(3'd3, 16'h0, 32'h0, 32'h0, 4'h0);
        check("ret_sp", sp, 12'hFFF);

        // INT then RETI.
        issue(3'd4, 16'h0, 32'h0000_0040, 32'h0, 4'b0101);
        check("int_sp", sp, 12'hFFC);
        issue(3'd5, 16'h0, 32'h0, 32'h0, 4'h0);
        check("reti_sp", sp, 12'hFFF);

        // req_valid held through a CALL: the next request is taken only after DONE.
        @(negedge clk);
        req_op = 3'd2; req_pc = 32'hCAFE_0123; req_target = 32'h0000_0200; req_valid = 1'b1;
        check("hold_ready_t0", req_ready, 1'b1);
        c0 = cyc;
        model_req(3'd2, 16'h0, 32'hCAFE_0123, 32'h0000_0200, 4'h0, c0);
        @(posedge clk);
        #1 req_op = 3'd0; req_data = 16'hBEEF;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("hold_ready_busy", {req_ready, busy}, 2'b01);
        end
        @(negedge clk);
        check("hold_ready_t4", req_ready, 1'b1);
        model_req(3'd0, 16'hBEEF, 32'h0, 32'h0, 4'h0, c0 + 4);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_idle();

        // Unwind to empty, then pop the empty stack.
        issue(3'd1, 16'h0, 32'h0, 32'h0, 4'h0);
        issue(3'd3, 16'h0, 32'h0, 32'h0, 4'h0);
        check("unwound_sp", sp, 12'hFFF);
        issue(3'd1, 16'h0, 32'h0, 32'h0, 4'h0);
        check("empty_pop_err", stack_err, BOUNDS);
        check("empty_pop_sp", sp, BOUNDS ? 12'hFFF : 12'h000);
        issue(3'd0, 16'h1234, 32'h0, 32'h0, 4'h0);
        check("err_sticky", stack_err, BOUNDS);

        // Reset lands after the second INT word is written.
        do_reset();
        @(negedge clk);
        req_op = 3'd4; req_pc = 32'h0000_0777; req_flags = 4'hA; req_valid = 1'b1;
        c0 = cyc;
        a3 = m_sp - 12'd2;
        saved = model_mem[a3];
        model_req(3'd4, 16'h0, 32'h0000_0777, 32'h0, 4'hA, c0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 check("midseq_ready", req_ready, 1'b1);
        check("midseq_pending_writes", mem_q.size(), 1);
        mem_q.delete();
        done_q.delete();
        m_sp = SP_RST;
        m_err = 1'b0;
        model_mem[a3] = saved;
        @(negedge clk);
        reset_checks();
        reset = 1'b1;

        // Fill down to 12'hEFF, then push once more past the limit.
        for (int i = 0; i < 256; i++) issue(3'd0, 16'(i), 32'h0, 32'h0, 4'h0);
        check("fill_sp", sp, 12'hEFF);
        issue(3'd0, 16'hDEAD, 32'h0, 32'h0, 4'h0);
        check("overflow_err", stack_err, BOUNDS);
        check("overflow_sp", sp, BOUNDS ? 12'hEFF : 12'hEFE);

        // Randomized traffic, illegal opcodes included.
        do_reset();
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            if (op > 3'd5) issue_illegal(op);
            else issue(op, 16'($urandom), $urandom, $urandom, 4'($urandom));
        end

        repeat (4) @(negedge clk);
        check("sb_mem_left", mem_q.size(), 0);
        check("sb_done_left", done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
